// File: rtl/window_stream_scheduler_if.sv
// Pixel stream, line-buffer strobe and window-read signal bundle for window_stream_scheduler.
// master = scheduler side, slave = pixel source / window generator side.
interface window_stream_scheduler_if #(
    parameter int NUM_LB = 7
);
    logic [7:0]        s_pixel;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        lb_pixel;
    logic [NUM_LB-1:0] lb_wr_en;
    logic              lb_rd_en;
    logic [2:0]        lb_rd_base;
    logic              m_ready;
    logic              win_valid;
    logic [8:0]        win_row;
    logic [8:0]        win_col;

    modport master (
        input  s_pixel, s_valid, m_ready,
        output s_ready, lb_pixel, lb_wr_en, lb_rd_en, lb_rd_base,
               win_valid, win_row, win_col
    );

    modport slave (
        output s_pixel, s_valid, m_ready,
        input  s_ready, lb_pixel, lb_wr_en, lb_rd_en, lb_rd_base,
               win_valid, win_row, win_col
    );
endinterface

// File: rtl/window_stream_scheduler.sv
// Line-buffer write/read scheduler for the rotating-buffer window generator.
// Optional stall-cycle counter enabled by defining WSS_STALL_CNT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; no pixels accepted
// FILL     | writing the first WIN lines, no reads yet
// STREAM   | writes continue, full-row read bursts issued on m_ready
// FLUSH    | all window rows issued; drop held lines, realign read base
// DONE     | one-cycle frame_done pulse, then back to IDLE
module window_stream_scheduler #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int WIN    = 6,
    parameter int NUM_LB = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    window_stream_scheduler_if.master bus,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic [3:0]                lines_full_o,
    output logic [31:0]               stall_cycles_o
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = $clog2(IMG_H + 1);

    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_END     = ROW_W'(IMG_H);
    localparam logic [ROW_W-1:0] RD_ROWS_END = ROW_W'(IMG_H - WIN + 1);
    localparam logic [3:0]       LB_CNT      = 4'(NUM_LB);
    localparam logic [3:0]       WIN_CNT     = 4'(WIN);
    localparam logic [3:0]       FLUSH_STEP  = 4'(WIN - 1);
    localparam logic [2:0]       LB_LAST     = 3'(NUM_LB - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state_q,      state_d;
    logic [COL_W-1:0] wr_col_q,     wr_col_d;
    logic [ROW_W-1:0] wr_row_q,     wr_row_d;
    logic [2:0]       wr_line_q,    wr_line_d;
    logic [COL_W-1:0] rd_col_q,     rd_col_d;
    logic [ROW_W-1:0] rd_rows_q,    rd_rows_d;
    logic [2:0]       rd_base_q,    rd_base_d;
    logic [3:0]       lines_full_q, lines_full_d;
    logic             rd_en_q,      rd_en_d;

    logic              wr_phase;
    logic              s_ready;
    logic              accept;
    logic              line_done;
    logic              burst_start;
    logic              burst_last;
    logic [3:0]        base_sum;
    logic [2:0]        base_flush;
    logic [NUM_LB-1:0] wr_en;

    function automatic logic [2:0] lb_inc(input logic [2:0] idx);
        return (idx == LB_LAST) ? 3'd0 : idx + 3'd1;
    endfunction

    always_comb begin
        wr_phase    = (state_q == S_FILL) || (state_q == S_STREAM);
        s_ready     = wr_phase && (wr_row_q < ROW_END) && (lines_full_q < LB_CNT);
        accept      = bus.s_valid && s_ready;
        line_done   = accept && (wr_col_q == COL_LAST);
        burst_start = (state_q == S_STREAM) && !rd_en_q && (lines_full_q >= WIN_CNT)
                      && bus.m_ready && (rd_rows_q < RD_ROWS_END);
        burst_last  = rd_en_q && (rd_col_q == COL_LAST);
        // Next frame's window row 0 must land on the buffer the next write goes to.
        base_sum    = {1'b0, rd_base_q} + FLUSH_STEP;
        base_flush  = (base_sum >= LB_CNT) ? 3'(base_sum - LB_CNT) : base_sum[2:0];
    end

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_LB; i++) begin
            if (accept && (wr_line_q == 3'(i))) wr_en[i] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_col_d     = wr_col_q;
        wr_row_d     = wr_row_q;
        wr_line_d    = wr_line_q;
        rd_col_d     = rd_col_q;
        rd_rows_d    = rd_rows_q;
        rd_base_d    = rd_base_q;
        lines_full_d = lines_full_q;
        rd_en_d      = rd_en_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_FILL;
                    wr_col_d     = '0;
                    wr_row_d     = '0;
                    rd_col_d     = '0;
                    rd_rows_d    = '0;
                    lines_full_d = '0;
                end
            end
            S_FILL: begin
                if (lines_full_q >= WIN_CNT) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (rd_rows_q == RD_ROWS_END) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d      = S_DONE;
                lines_full_d = '0;
                rd_base_d    = base_flush;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            if (wr_col_q == COL_LAST) begin
                wr_col_d  = '0;
                wr_row_d  = wr_row_q + ROW_W'(1);
                wr_line_d = lb_inc(wr_line_q);
            end else begin
                wr_col_d = wr_col_q + COL_W'(1);
            end
        end

        if (burst_start) begin
            rd_en_d  = 1'b1;
            rd_col_d = '0;
        end else if (rd_en_q) begin
            if (burst_last) begin
                rd_en_d   = 1'b0;
                rd_col_d  = '0;
                rd_rows_d = rd_rows_q + ROW_W'(1);
                rd_base_d = lb_inc(rd_base_q);
            end else begin
                rd_col_d = rd_col_q + COL_W'(1);
            end
        end

        // A line completing on the same edge a burst releases one nets to zero.
        if (line_done && !burst_last) begin
            lines_full_d = lines_full_q + 4'd1;
        end else if (!line_done && burst_last) begin
            lines_full_d = lines_full_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wr_col_q     <= '0;
            wr_row_q     <= '0;
            wr_line_q    <= '0;
            rd_col_q     <= '0;
            rd_rows_q    <= '0;
            rd_base_q    <= '0;
            lines_full_q <= '0;
            rd_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_col_q     <= wr_col_d;
            wr_row_q     <= wr_row_d;
            wr_line_q    <= wr_line_d;
            rd_col_q     <= rd_col_d;
            rd_rows_q    <= rd_rows_d;
            rd_base_q    <= rd_base_d;
            lines_full_q <= lines_full_d;
            rd_en_q      <= rd_en_d;
        end
    end

`ifdef WSS_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && start_i) begin
            stall_q <= '0;
        end else if ((state_q != S_IDLE) && bus.s_valid && !s_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif

    assign bus.s_ready    = s_ready;
    assign bus.lb_pixel   = bus.s_pixel;
    assign bus.lb_wr_en   = wr_en;
    assign bus.lb_rd_en   = rd_en_q;
    assign bus.win_valid  = rd_en_q;
    assign bus.lb_rd_base = rd_base_q;
    assign bus.win_row    = 9'(rd_rows_q);
    assign bus.win_col    = 9'(rd_col_q);
    assign busy_o         = (state_q != S_IDLE);
    assign frame_done_o   = (state_q == S_DONE);
    assign lines_full_o   = lines_full_q;

endmodule

// File: tb/tb_window_stream_scheduler.sv
// Scoreboard bench for window_stream_scheduler: randomized pixel/m_ready traffic,
// expected writes and window reads derived from frame geometry.
module tb_window_stream_scheduler;

    localparam int IMG_W     = 16;
    localparam int IMG_H     = 12;
    localparam int WIN       = 6;
    localparam int NUM_LB    = 7;
    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int NROWS     = IMG_H - WIN + 1;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [3:0]  lines_full;
    logic [31:0] stall_cycles;

    window_stream_scheduler_if #(.NUM_LB(NUM_LB)) bus ();

    window_stream_scheduler #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN),
        .NUM_LB(NUM_LB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .bus           (bus),
        .busy_o        (busy),
        .frame_done_o  (frame_done),
        .lines_full_o  (lines_full),
        .stall_cycles_o(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] wr_q[$];   // {line index, pixel}
    logic [20:0] rd_q[$];   // {win_row, win_col, lb_rd_base}

    int wr_cnt   = 0;
    int rel_cnt  = 0;
    int done_cnt = 0;
    int lb_base  = 0;
    int pix_idx  = 0;
    int mr_mode  = 0;
    int m_occ;
    logic        prev_valid = 1'b0;
    logic [8:0]  prev_col   = '0;
    logic [10:0] m_we;
    logic [20:0] m_re;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_mr(input int mode);
        mr_mode = mode;
        bus.m_ready = (mode == 1);
    endtask

    // m_ready source: held low, held high, or random.
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0:       bus.m_ready = 1'b0;
                1:       bus.m_ready = 1'b1;
                default: bus.m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: flow-control model plus scoreboard pops for writes and window reads.
    always @(negedge clk) begin
        if (reset) begin
            if (busy && (rel_cnt < NROWS)) begin
                m_occ = wr_cnt / IMG_W - rel_cnt;
                chk("lines_full", lines_full, m_occ);
                chk("s_ready", bus.s_ready, (wr_cnt < FRAME_PIX) && (m_occ < NUM_LB));
            end
            if (prev_valid && (prev_col != 9'(IMG_W - 1)))
                chk("burst_contiguous", bus.win_valid, 1);
            if (bus.win_valid) begin
                chk("lb_rd_en", bus.lb_rd_en, 1);
                if (bus.win_col == 0)
                    chk("burst_data_ready", (wr_cnt / IMG_W) >= (int'(bus.win_row) + WIN), 1);
                if (rd_q.size() == 0) begin
                    chk("read_unexpected", 1, 0);
                end else begin
                    m_re = rd_q.pop_front();
                    chk("win_row", bus.win_row, m_re[20:12]);
                    chk("win_col", bus.win_col, m_re[11:3]);
                    chk("lb_rd_base", bus.lb_rd_base, m_re[2:0]);
                end
                if (bus.win_col == 9'(IMG_W - 1)) rel_cnt++;
            end
            if (bus.lb_wr_en != '0) begin
                if (wr_q.size() == 0) begin
                    chk("write_unexpected", 1, 0);
                end else begin
                    m_we = wr_q.pop_front();
                    chk("lb_wr_en", bus.lb_wr_en, 64'd1 << m_we[10:8]);
                    chk("lb_pixel", bus.lb_pixel, m_we[7:0]);
                end
                wr_cnt++;
            end
            if (frame_done) done_cnt++;
            prev_valid = bus.win_valid;
            prev_col   = bus.win_col;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic frame_begin();
        for (int r = 0; r < NROWS; r++)
            for (int c = 0; c < IMG_W; c++)
                rd_q.push_back({9'(r), 9'(c), 3'((lb_base + r) % NUM_LB)});
        wr_cnt   = 0;
        rel_cnt  = 0;
        done_cnt = 0;
        pix_idx  = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic present_pixel(input logic [7:0] v);
        wr_q.push_back({3'(((lb_base + pix_idx / IMG_W) % NUM_LB)), v});
        pix_idx++;
        bus.s_pixel = v;
        bus.s_valid = 1'b1;
    endtask

    task automatic wait_accept();
        logic ok;
        ok = 1'b0;
        for (int i = 0; (i < 4000) && !ok; i++) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_pixel(input int idle_max);
        repeat ($urandom_range(0, idle_max)) begin
            @(posedge clk);
            #1;
        end
        present_pixel(8'($urandom));
        wait_accept();
    endtask

    task automatic wait_win(input int col);
        logic hit;
        hit = 1'b0;
        for (int i = 0; (i < 2000) && !hit; i++) begin
            @(negedge clk);
            hit = bus.win_valid && (bus.win_col == 9'(col));
        end
        if (!hit) chk("burst_timeout", 0, 1);
    endtask

    task automatic finish_frame();
        logic hit;
        hit = 1'b0;
        for (int i = 0; (i < 5000) && !hit; i++) begin
            @(negedge clk);
            hit = frame_done;
        end
        if (!hit) chk("frame_done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        lb_base = (lb_base + IMG_H) % NUM_LB;
        chk("frame_done_pulses", done_cnt, 1);
        chk("pixels_accepted", wr_cnt, FRAME_PIX);
        chk("bursts_done", rel_cnt, NROWS);
        chk("writes_pending", wr_q.size(), 0);
        chk("reads_pending", rd_q.size(), 0);
        chk("idle_after_frame", busy, 0);
        chk("lines_full_after_frame", lines_full, 0);
        chk("rd_base_aligned", bus.lb_rd_base, lb_base);
    endtask

    task automatic run_frame(input int idle_max, input int mode);
        frame_begin();
        set_mr(mode);
        while (pix_idx < FRAME_PIX) send_pixel(idle_max);
        finish_frame();
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_pixel = '0;

        // Held in reset: toggling s_valid and start must have no effect.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.s_valid = ~bus.s_valid;
            start       = 1'b1;
            @(negedge clk);
            chk("rst_s_ready", bus.s_ready, 0);
            chk("rst_lb_wr_en", bus.lb_wr_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_win_valid", bus.win_valid, 0);
            chk("rst_lines_full", lines_full, 0);
        end
        start       = 1'b0;
        bus.s_valid = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_frame_done", frame_done, 0);
        chk("idle_rd_base", bus.lb_rd_base, 0);
        chk("idle_win_row", bus.win_row, 0);
        chk("idle_win_col", bus.win_col, 0);
        chk("idle_stall", stall_cycles, 0);

        // Directed frame: fill, stall at a full buffer set, burst, simultaneous release.
        frame_begin();
        set_mr(0);
        for (int k = 0; k < 96; k++) send_pixel(0);
        chk("fill_lines_full6", lines_full, 6);
        repeat (3) @(posedge clk);
        #1;
        chk("fill_no_read", bus.lb_rd_en, 0);
        for (int k = 0; k < 16; k++) send_pixel(0);
        chk("fill_lines_full7", lines_full, 7);
        chk("full_s_ready_low", bus.s_ready, 0);
        present_pixel(8'($urandom));
        repeat (10) @(posedge clk);
        #1;
`ifdef WSS_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, 10);
`else
        chk("stall_cycles", stall_cycles, 0);
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_ignored_busy", busy, 1);
        chk("start_ignored_lines", lines_full, 7);
        set_mr(1);
        wait_win(0);
        @(posedge clk);
        #1 set_mr(0);
        wait_accept();
        chk("burst_end_lines_full", lines_full, 6);
        chk("burst_end_rd_base", bus.lb_rd_base, 1);
        chk("burst_end_s_ready", bus.s_ready, 1);
        for (int k = 0; k < 14; k++) send_pixel(0);
        chk("pre_simul_lines_full", lines_full, 6);
        set_mr(1);
        wait_win(0);
        @(posedge clk);
        #1 set_mr(0);
        wait_win(14);
        @(posedge clk);
        #1 present_pixel(8'($urandom));
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
        chk("simul_lines_full", lines_full, 6);
        chk("simul_rd_base", bus.lb_rd_base, 2);
        chk("simul_burst_over", bus.win_valid, 0);
        set_mr(2);
        while (pix_idx < FRAME_PIX) send_pixel(3);
        finish_frame();

        // Continuous traffic, then randomized frames.
        run_frame(0, 1);
        run_frame(3, 2);
        run_frame(1, 2);

        // Reset in the middle of a burst.
        frame_begin();
        set_mr(0);
        for (int k = 0; k < 96; k++) send_pixel(0);
        set_mr(1);
        wait_win(5);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_rd_en", bus.lb_rd_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_lines_full", lines_full, 0);
        chk("abort_s_ready", bus.s_ready, 0);
        chk("abort_rd_base", bus.lb_rd_base, 0);
        chk("abort_win_col", bus.win_col, 0);
        wr_q.delete();
        rd_q.delete();
        lb_base = 0;
        set_mr(0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        run_frame(2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_stream_scheduler.md
Name: window_stream_scheduler

Overview:
Sequences the 6x6 window generator (7 rotating line buffers of one image line each). It accepts a pixel stream under valid/ready, issues per-line-buffer write strobes, and schedules full-row read bursts. Upstream is throttled when no free line buffer exists. The block tracks frame row/column position and signals end of frame. It sits between the pixel source and the window generator; window-consuming stages drive m_ready.

Parameters:
IMG_W, 512, pixels per line (columns per read burst)
IMG_H, 512, lines per frame
WIN, 6, window height in lines
NUM_LB, 7, number of line buffers (must be > WIN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset (0 = reset)
start  in  1  frame start pulse; ignored unless in IDLE
s_pixel  in  8  upstream pixel
s_valid  in  1  upstream pixel valid
s_ready  out  1  scheduler accepts pixel this cycle
lb_pixel  out  8  pixel to line buffers (= s_pixel, combinational)
lb_wr_en  out  NUM_LB  one-hot write strobe, bit lb_wr_line = s_valid & s_ready
lb_rd_en  out  1  read-burst enable to window generator
lb_rd_base  out  3  index of oldest line buffer (window row 0)
m_ready  in  1  downstream can accept a full window row
win_valid  out  1  window output valid (= lb_rd_en)
win_row  out  9  top-line index of current window row
win_col  out  9  column index of current window
lines_full  out  4  completely written, unreleased lines
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at end of frame
stall_cycles  out  32  see Optional Feature

Behaviour:
- Reset (reset=0, async): state=IDLE; all counters, lb_rd_base, internal wr_line, lines_full, win_row, win_col = 0; s_ready, lb_rd_en, frame_done = 0.
- States: IDLE, FILL, STREAM, FLUSH, DONE.
- IDLE: start=1 -> FILL; clear wr_col, wr_row, rd_col, rd_rows, lines_full.
- Write path (FILL, STREAM): s_ready = (wr_row < IMG_H) & (lines_full < NUM_LB-1 or end of read burst this cycle) is NOT used; s_ready = (wr_row < IMG_H) & (lines_full < NUM_LB). Accept = s_valid & s_ready. On accept: wr_col++. At wr_col==IMG_W-1 accept: wr_col=0, wr_row++, wr_line=(wr_line+1)%NUM_LB, lines_full+1. s_valid low mid-line: counters hold.
- FILL -> STREAM when lines_full >= WIN (registered value).
- Read burst (STREAM): starts when not bursting & lines_full >= WIN & m_ready & rd_rows < IMG_H-WIN+1. lb_rd_en is asserted the cycle after the start decision and held exactly IMG_W consecutive cycles. m_ready is sampled only at burst start. win_col=rd_col 0..IMG_W-1; win_row=rd_rows. On last burst cycle: rd_rows++, lb_rd_base=(lb_rd_base+1)%NUM_LB, lines_full-1.
- Same-cycle line complete and burst end: lines_full unchanged.
- Writes continue during bursts; this is the steady state. A full line buffer (lines_full==NUM_LB) deasserts s_ready until a burst releases a line.
- STREAM -> FLUSH when rd_rows == IMG_H-WIN+1 (all window rows issued). FLUSH (1 cycle): lines_full=0, lb_rd_base=(lb_rd_base+WIN-1)%NUM_LB so the next frame starts aligned with wr_line -> DONE.
- DONE (1 cycle): frame_done=1 -> IDLE.
- start outside IDLE has no effect. Reset mid-burst aborts immediately; outputs take reset values.
- Widths: all mod-NUM_LB arithmetic is done on 3-bit indices with explicit wrap at NUM_LB-1 (no % on non-power-of-2 in RTL).

Optional Feature:
Macro WSS_STALL_CNT_EN.
- Defined: stall_cycles counts cycles where s_valid & !s_ready while busy. It saturates at 2^32-1, clears on accepted start, and is held through IDLE.
- Undefined: stall_cycles tied to 0 and no counter logic is present.

Test Plan:
(Bench uses IMG_W=16, IMG_H=12, WIN=6, NUM_LB=7.)
- Reset/idle: hold reset=0, toggle s_valid -> s_ready=0, lb_wr_en=0, busy=0; start while reset=0 ignored.
- Fill: start, stream 96 pixels continuously with m_ready=0 -> lines_full reaches 6, state STREAM, lb_rd_en=0. Stream 16 more -> lines_full=7, s_ready=0 at pixel 113.
- Burst: raise m_ready -> lb_rd_en high exactly 16 cycles, win_row=0, win_col 0..15. At burst end lines_full=6, lb_rd_base=1, and s_ready reasserts.
- Full frame: continuous s_valid, m_ready=1 -> exactly 7 bursts (win_row 0..6) and 192 accepted pixels. frame_done pulses once; lb_wr_en bit index wraps 6->0.
- Simultaneous: align the last write of a line with the last burst cycle -> lines_full unchanged that cycle.
- Abort and optional feature: reset low mid-burst -> lb_rd_en=0 asynchronously, then a clean new frame. With WSS_STALL_CNT_EN, hold s_valid=1 for 10 cycles at lines_full=7 -> stall_cycles=10.
